multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter ENABLE_ADDI, default 1: 1 adds addi (opcode 001000) support; 0 makes addi illegal.
REQ-002 Parameter ENABLE_JUMP, default 1: 1 adds j (opcode 000010) support; 0 makes j illegal.
REQ-003 Parameter MAX_WAIT, default 15: maximum number of mem_ready wait cycles before timeout; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Op  input  6  instruction opcode from IR, sampled in DECODE.
REQ-007 mem_ready  input  1  memory completion handshake for FETCH/MEMRD/MEMWR.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-009 PCSource, ALUSrcB, ALUOp  output  2 each  datapath mux/ALU controls.
REQ-010 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 mem_timeout  output  1  one-cycle pulse when a memory wait exceeds MAX_WAIT.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; other codes return to FETCH.
REQ-014 Outputs are Moore decodes of state; every signal not listed for a state is 0.
REQ-015 FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready; the FSM stays in FETCH until mem_ready=1, then moves to DECODE.
REQ-016 DECODE: ALUSrcB=11. Next state by Op: 000000->EXEC; 100011/101011->MEMADR; 000100->BRANCH; 000010->JUMP (if enabled); 001000->ADDI_EX (if enabled).
REQ-017 Any other Op in DECODE pulses illegal_op for that cycle and goes to FETCH.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10; next state MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: MemRead=1, IorD=1; holds until mem_ready, then moves to MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, then FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; holds until mem_ready, then FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUOp=10, then RWB.
REQ-023 RWB: RegDst=1, RegWrite=1, then FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10, then FETCH.
REQ-026 ADDI_EX: ALUSrcA=1, ALUSrcB=10, then ADDI_WB.
REQ-027 ADDI_WB: RegWrite=1, then FETCH.
REQ-028 With zero wait states, latency is R/sw/addi 4 cycles, lw 5, beq/j 3.
REQ-029 An 8-bit wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle that state holds with mem_ready=0.
REQ-030 If the wait counter reaches MAX_WAIT with mem_ready=0, the FSM pulses mem_timeout and goes to FETCH with no IRWrite/PCWrite/RegWrite in that cycle.
REQ-031 mem_ready=1 on the timeout cycle takes priority as a normal completion.
REQ-032 mem_ready is ignored in states that do not wait on memory.

Reset
REQ-033 While rst_n=0, state=FETCH, the wait counter is 0, and every output is forced to 0.
REQ-034 Reset asserted mid-instruction aborts it immediately, with no partial register or memory write after release.
REQ-035 The first cycle after release is FETCH.

Structure
REQ-036 Package mcc_pkg holds the state enum/constants, opcode constants, and the ALUOp/ALUSrcB/PCSource encodings.
REQ-037 Combinational sub-module opcode_decode maps Op plus enable parameters to one-hot rformat/lw/sw/beq/j/addi/illegal.

Verification
REQ-038 lw (100011), mem_ready always 1 -> states 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4.
REQ-039 R-type (000000) -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegDst=RegWrite=1 in RWB.
REQ-040 sw with mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, then FETCH; no RegWrite at any point.
REQ-041 ENABLE_JUMP=0, Op=000010 -> illegal_op=1 in DECODE cycle only, next state FETCH, PCWrite stays 0.
REQ-042 MAX_WAIT=4, mem_ready stuck 0 in FETCH -> mem_timeout pulses once, IRWrite never 1, FSM re-enters FETCH.
REQ-043 rst_n dropped during MEMRD -> all outputs 0 asynchronously; after release state=0 and the wait counter is 0.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM:
// state codes, opcodes and the datapath mux/ALU select values.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that sit on the mem_ready handshake and own the wait counter.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multi_cycle_control_opcode_decode.sv
// Combinational opcode classifier: exactly one of the class outputs is high,
// with optional instructions folded into illegal when disabled.
module opcode_decode
  import mcc_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic [5:0] op_i,
  output logic       rformat_o,
  output logic       lw_o,
  output logic       sw_o,
  output logic       beq_o,
  output logic       j_o,
  output logic       addi_o,
  output logic       illegal_o
);

  assign rformat_o = (op_i == OP_RTYPE);
  assign lw_o      = (op_i == OP_LW);
  assign sw_o      = (op_i == OP_SW);
  assign beq_o     = (op_i == OP_BEQ);
  assign j_o       = ENABLE_JUMP && (op_i == OP_J);
  assign addi_o    = ENABLE_ADDI && (op_i == OP_ADDI);
  assign illegal_o = !(rformat_o || lw_o || sw_o || beq_o || j_o || addi_o);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM with a bounded memory-wait counter.
// Handshake: in FETCH/MEMRD/MEMWR the FSM holds until mem_ready=1 (completion that cycle); elsewhere mem_ready is ignored.
module multi_cycle_control
  import mcc_pkg::*;
#(
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter bit          ENABLE_JUMP = 1'b1,
  parameter int unsigned MAX_WAIT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_lw_q, is_lw_d;
  logic       dec_r, dec_lw, dec_sw, dec_beq, dec_j, dec_addi, dec_ill;
  logic       timeout;

  opcode_decode #(
    .ENABLE_ADDI(ENABLE_ADDI),
    .ENABLE_JUMP(ENABLE_JUMP)
  ) u_opcode_decode (
    .op_i     (Op),
    .rformat_o(dec_r),
    .lw_o     (dec_lw),
    .sw_o     (dec_sw),
    .beq_o    (dec_beq),
    .j_o      (dec_j),
    .addi_o   (dec_addi),
    .illegal_o(dec_ill)
  );

  assign timeout = is_mem_wait(state_q) && !mem_ready && (wait_q == WAIT_LIMIT);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      is_lw_q <= is_lw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
                 else if (timeout) state_d = S_FETCH;
      S_DECODE: begin
        // Op is only trusted here; remember lw vs sw for MEMADR.
        is_lw_d = dec_lw;
        if (dec_r)                  state_d = S_EXEC;
        else if (dec_lw || dec_sw)  state_d = S_MEMADR;
        else if (dec_beq)           state_d = S_BRANCH;
        else if (dec_j)             state_d = S_JUMP;
        else if (dec_addi)          state_d = S_ADDI_EX;
        else                        state_d = S_FETCH;
      end
      S_MEMADR:  state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
                 else if (timeout) state_d = S_FETCH;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready || timeout) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
    // Any state change (including timeout re-entry to FETCH) restarts the count.
    wait_d = '0;
    if (is_mem_wait(state_q) && !mem_ready && !timeout) wait_d = wait_q + 8'd1;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (rst_n) begin
      mem_timeout = timeout;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_BRIMM;
          illegal_op = dec_ill;
        end
        S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
        S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
        S_EXEC:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_FUNCT; end
        S_RWB:     begin RegDst = 1'b1; RegWrite = 1'b1; end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP:    begin PCWrite = 1'b1; PCSource = PCSRC_JUMP; end
        S_ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
        S_ADDI_WB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
